sockit_spi_xip_seq: RTL
=======================

Name: sockit_spi_xip_seq

Overview:
- Flash read sequencer that sits directly upstream of the SPI serializer.
- Turns a 32-bit memory-mapped read request into a sequence of serializer commands on the command stream, with paired shift data on the data-write stream: opcode, address, dummy, data, deselect.
- Collects the returned word from the serializer's data-read stream and presents it as a read response.
- Supports single, dual and quad I/O per phase.

Parameters:
- ADW, 24, request address width in bits; 24 or 32.
- CNW, 14, width of the command cycle counter field.

Ports:
- clk  in  1  clock, shared with the serializer.
- rst  in  1  asynchronous, active-low reset.
- cfg_cmd  in  8  read opcode.
- cfg_iom_cmd / cfg_iom_adr / cfg_iom_dat  in  2 each  I/O mode per phase: 0/1 = single, 2 = dual, 3 = quad.
- cfg_dmy  in  4  dummy clock cycles; 0 = no dummy phase.
- cfg_adr4  in  1  1 = 32-bit address phase, 0 = 24-bit.
- req_vld, req_rdy  in, out  1  read request handshake.
- req_adr  in  ADW  byte address.
- rsp_vld  out  1  response valid, single-cycle pulse.
- rsp_dat  out  32  read data.
- scw_vld, scw_rdy  out, in  1  command stream handshake.
- scw_sso, scw_cke, scw_die, scw_doe  out  1 each  slave select, clock enable, data-in enable, data-out enable.
- scw_iom  out  2  I/O mode of the current command.
- scw_cnt  out  CNW  SPI clock cycles minus 1.
- sdw_vld, sdw_rdy  out, in  1  write-data handshake.
- sdw_dat  out  32  left-aligned shift data.
- sdr_vld  in  1  read-data valid.
- sdr_dat  in  32  read data, right-aligned.

Behaviour:
- Reset (rst low): FSM goes to IDLE. All outputs are 0 except req_rdy, which is 1. An in-flight transfer is abandoned; no deselect command is issued.
- Transfer rule: a command transfers when scw_vld and scw_rdy are both high. The FSM advances only on a transfer.
  - sdw_vld equals scw_vld in CMD and ADR, and is 0 elsewhere.
  - sdw_dat is held stable until the transfer.
- Bits per cycle: B = 1, 2 or 4, from the phase's iom (modes 0/1 give B = 1).
- States and commands:
  - IDLE: req_rdy = 1. On req_vld, latch req_adr and the cfg values, go to CMD. req_rdy is 0 in every other state.
  - CMD: sso=1, cke=1, doe=1, die=0, iom=cfg_iom_cmd, cnt=8/B-1 (7/3/1), sdw_dat={cmd,24'h0}. Next state is ADR.
  - ADR: sso=1, cke=1, doe=1, die=0, iom=cfg_iom_adr, cnt=A/B-1 with A = 24 or 32. sdw_dat = {adr[23:0],8'h0} or adr[31:0]. Next state is DMY if cfg_dmy != 0, else DAT.
  - DMY: sso=1, cke=1, doe=0, die=0, iom=cfg_iom_dat, cnt=cfg_dmy-1. Next state is DAT.
  - DAT: sso=1, cke=1, doe=0, die=1, iom=cfg_iom_dat, cnt=32/B-1 (31/15/7). Next state is WAIT.
  - WAIT: scw_vld=0. On sdr_vld, register sdr_dat into rsp_dat; rsp_vld pulses high the next cycle. Next state is END.
  - END: sso=0, cke=0, doe=0, die=0, cnt=0. Next state is IDLE.
- Latency: the request-to-first-command path is 1 cycle (registered outputs).
- rsp_dat holds its value until the next response.
- When ADW=24, cfg_adr4 is ignored and treated as 0.
- Arithmetic: cnt is zero-extended to CNW bits.
- Address handling: the address is never incremented in the base build.
- Config changes after request acceptance have no effect until the next request.
- sdr_vld in any state other than WAIT is ignored.

Optional Feature:
- Macro: SOCKIT_SPI_XIP_SEQ_CONT_EN (continuous sequential read).
- With the macro defined:
  - WAIT goes to HOLD instead of END. In HOLD, scw_vld=0, sso stays 1 and req_rdy=1.
  - A request with req_adr equal to last address + 4 (modulo 2^ADW) goes directly to DAT, skipping CMD, ADR and DMY.
  - Any other address, or 256 idle cycles in HOLD, issues END. For a non-sequential request, that request is latched, then END is issued, then CMD follows.
- Without the macro: the HOLD state, its timeout counter and the address comparator do not exist.

Test Plan:
- Single mode: cfg_cmd=8'h03, all iom=0, cfg_dmy=0, req_adr=24'h123456 -> three commands:
  - cnt=7, sdw_dat=32'h03000000;
  - cnt=23, sdw_dat=32'h12345600;
  - cnt=31, die=1;
  - then sdr_vld with sdr_dat=32'hDEADBEEF gives rsp_dat=32'hDEADBEEF one cycle later, followed by an END command with sso=0.
- Quad fast read: cfg_cmd=8'hEB, iom_cmd=0, iom_adr=3, iom_dat=3, cfg_dmy=6 -> cnt sequence 7, 5, 5, 7; DMY has doe=0, die=0.
- 32-bit address: ADW=32, cfg_adr4=1, dual address, req_adr=32'h89ABCDEF -> ADR command cnt=15, sdw_dat=32'h89ABCDEF.
- Backpressure: hold scw_rdy=0 for 10 cycles during ADR -> scw_vld, sdw_vld and all fields remain stable; exactly one transfer occurs.
- Reset: assert rst during DMY -> next cycle all outputs are 0, req_rdy=1; a subsequent request completes normally.
- CONT_EN: read 0x100, then 0x104 within 10 cycles -> second read issues only a DAT command. Then read 0x200 -> END, then CMD. Then idle 256 cycles in HOLD -> END issued.

Source files
------------

// File: rtl/sockit_spi_xip_seq.sv
// XIP flash read sequencer: turns a memory-mapped read into opcode/address/dummy/data/deselect serializer commands.
// Optional continuous sequential read (HOLD state) is enabled by defining SOCKIT_SPI_XIP_SEQ_CONT_EN.
module sockit_spi_xip_seq #(
  parameter int ADW = 24,
  parameter int CNW = 14
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     cfg_cmd,
  input  logic [1:0]     cfg_iom_cmd,
  input  logic [1:0]     cfg_iom_adr,
  input  logic [1:0]     cfg_iom_dat,
  input  logic [3:0]     cfg_dmy,
  input  logic           cfg_adr4,
  input  logic           req_vld,
  output logic           req_rdy,
  input  logic [ADW-1:0] req_adr,
  output logic           rsp_vld,
  output logic [31:0]    rsp_dat,
  output logic           scw_vld,
  input  logic           scw_rdy,
  output logic           scw_sso,
  output logic           scw_cke,
  output logic           scw_die,
  output logic           scw_doe,
  output logic [1:0]     scw_iom,
  output logic [CNW-1:0] scw_cnt,
  output logic           sdw_vld,
  input  logic           sdw_rdy,
  output logic [31:0]    sdw_dat,
  input  logic           sdr_vld,
  input  logic [31:0]    sdr_dat
);

  // IDLE: wait request | CMD: opcode | ADR: address | DMY: dummy | DAT: data | WAIT: read-back | END: deselect | HOLD: sso kept for next sequential read
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADR, S_DMY, S_DAT, S_WAIT,
`ifdef SOCKIT_SPI_XIP_SEQ_CONT_EN
    S_END, S_HOLD
`else
    S_END
`endif
  } state_t;

  state_t          state_q, state_nx;
  logic [ADW-1:0]  adr_q;
  logic [7:0]      cmd_q;
  logic [1:0]      iom_cmd_q, iom_adr_q, iom_dat_q;
  logic [3:0]      dmy_q;
  logic            adr4_q;
  logic [31:0]     adr_ext;
  logic            seq_hit;

  assign adr_ext = 32'(adr_q);

  function automatic logic [CNW-1:0] cyc(input logic [5:0] bits, input logic [1:0] iom);
    logic [5:0] n;
    case (iom)
      2'd2:    n = bits >> 1;
      2'd3:    n = bits >> 2;
      default: n = bits;
    endcase
    return CNW'(n - 6'd1);
  endfunction

`ifdef SOCKIT_SPI_XIP_SEQ_CONT_EN
  logic [7:0] tmr_q;
  logic       pend_q;

  assign seq_hit = (state_q == S_HOLD) && (req_adr == adr_q + ADW'(4));

  // Idle timer reloads while waiting for read data, so HOLD always starts from a full count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q  <= 8'd0;
      pend_q <= 1'b0;
    end else begin
      if (state_q == S_WAIT)
        tmr_q <= 8'd255;
      else if (state_q == S_HOLD && tmr_q != 8'd0)
        tmr_q <= tmr_q - 8'd1;
      if (state_q == S_HOLD && req_vld && !seq_hit)
        pend_q <= 1'b1;
      else if (state_q == S_END && scw_rdy)
        pend_q <= 1'b0;
    end
  end
`else
  assign seq_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      cmd_q     <= 8'd0;
      iom_cmd_q <= 2'd0;
      iom_adr_q <= 2'd0;
      iom_dat_q <= 2'd0;
      dmy_q     <= 4'd0;
      adr4_q    <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_dat   <= 32'd0;
    end else begin
      state_q <= state_nx;
      if (req_vld && req_rdy) begin
        adr_q <= req_adr;
        if (!seq_hit) begin
          cmd_q     <= cfg_cmd;
          iom_cmd_q <= cfg_iom_cmd;
          iom_adr_q <= cfg_iom_adr;
          iom_dat_q <= cfg_iom_dat;
          dmy_q     <= cfg_dmy;
          adr4_q    <= (ADW == 32) ? cfg_adr4 : 1'b0;
        end
      end
      rsp_vld <= (state_q == S_WAIT) && sdr_vld;
      if (state_q == S_WAIT && sdr_vld)
        rsp_dat <= sdr_dat;
    end
  end

  // Opcode and address commands carry paired shift data, so both streams must accept together.
  always_comb begin
    state_nx = state_q;
    req_rdy  = 1'b0;
    scw_vld  = 1'b0;
    scw_sso  = 1'b0;
    scw_cke  = 1'b0;
    scw_die  = 1'b0;
    scw_doe  = 1'b0;
    scw_iom  = 2'd0;
    scw_cnt  = '0;
    sdw_vld  = 1'b0;
    sdw_dat  = 32'd0;
    case (state_q)
      S_IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) state_nx = S_CMD;
      end
      S_CMD: begin
        scw_vld = 1'b1; scw_sso = 1'b1; scw_cke = 1'b1; scw_doe = 1'b1;
        scw_iom = iom_cmd_q;
        scw_cnt = cyc(6'd8, iom_cmd_q);
        sdw_vld = 1'b1;
        sdw_dat = {cmd_q, 24'h0};
        if (scw_rdy && sdw_rdy) state_nx = S_ADR;
      end
      S_ADR: begin
        scw_vld = 1'b1; scw_sso = 1'b1; scw_cke = 1'b1; scw_doe = 1'b1;
        scw_iom = iom_adr_q;
        scw_cnt = cyc(adr4_q ? 6'd32 : 6'd24, iom_adr_q);
        sdw_vld = 1'b1;
        sdw_dat = adr4_q ? adr_ext : {adr_ext[23:0], 8'h00};
        if (scw_rdy && sdw_rdy) state_nx = (dmy_q != 4'd0) ? S_DMY : S_DAT;
      end
      S_DMY: begin
        scw_vld = 1'b1; scw_sso = 1'b1; scw_cke = 1'b1;
        scw_iom = iom_dat_q;
        scw_cnt = CNW'(dmy_q - 4'd1);
        if (scw_rdy) state_nx = S_DAT;
      end
      S_DAT: begin
        scw_vld = 1'b1; scw_sso = 1'b1; scw_cke = 1'b1; scw_die = 1'b1;
        scw_iom = iom_dat_q;
        scw_cnt = cyc(6'd32, iom_dat_q);
        if (scw_rdy) state_nx = S_WAIT;
      end
      S_WAIT: begin
`ifdef SOCKIT_SPI_XIP_SEQ_CONT_EN
        if (sdr_vld) state_nx = S_HOLD;
`else
        if (sdr_vld) state_nx = S_END;
`endif
      end
      S_END: begin
        scw_vld = 1'b1;
`ifdef SOCKIT_SPI_XIP_SEQ_CONT_EN
        if (scw_rdy) state_nx = pend_q ? S_CMD : S_IDLE;
`else
        if (scw_rdy) state_nx = S_IDLE;
`endif
      end
`ifdef SOCKIT_SPI_XIP_SEQ_CONT_EN
      S_HOLD: begin
        scw_sso = 1'b1;
        req_rdy = 1'b1;
        if (req_vld) state_nx = seq_hit ? S_DAT : S_END;
        else if (tmr_q == 8'd0) state_nx = S_END;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
